rc4_message_checker: RTL and testbench

// - Reads the decrypted-message RAM written by the RC4 PRGA stage, one byte per address, k = 0..MSG_LEN-1.
// - Checks every byte against the plaintext alphabet (lowercase a-z and space).
// - Reports key_valid or key_invalid, plus the first failing index, to the key-search controller.
// - Sits after the decrypt stage; its read port shares the decrypted RAM with the decrypt write port (mux is external).

---
 rtl/rc4_message_checker.sv | 165 ++++++++++++++++
 tb/tb_rc4_message_checker.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/rc4_message_checker.sv
// rc4_message_checker
//
// Purpose: after the RC4 decrypt stage has filled the decrypted-message RAM,
// this block reads bytes 0..MSG_LEN-1 one at a time. Each byte must be in the
// plaintext alphabet: space or lowercase a-z. The block reports key_valid when
// every byte passes. Otherwise it reports key_invalid together with the index
// of the first rejected byte. The check stops at that first rejected byte.
//
// Optional feature macro: ALLOW_UPPER_EN
//   When defined, uppercase A-Z (8'h41..8'h5A) is also accepted.
//   When undefined, uppercase is rejected like any other out-of-set byte.
//   Timing is the same in both builds.
//
// Parameters:
//   MSG_LEN   number of message bytes checked
//   ADDR_W    width of the RAM address and of fail_index
//   READ_LAT  clocks from address_d to valid q_d (legal range 1..4)
//
// Ports:
//   clk          system clock, rising edge
//   reset        synchronous active-high reset, returns to IDLE
//   start        level from the decrypt stage; a rising edge launches a check
//   address_d    decrypted-RAM read address
//   q_d          decrypted-RAM read data
//   busy         high while a check is in progress
//   done         high once a result is available (PASS or FAIL)
//   key_valid    high in PASS only
//   key_invalid  high in FAIL only
//   fail_index   index of the first rejected byte, 0 unless FAIL

module rc4_message_checker #(
  parameter int MSG_LEN  = 32,
  parameter int ADDR_W   = 8,
  parameter int READ_LAT = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic [ADDR_W-1:0] address_d,
  input  logic [7:0]        q_d,
  output logic              busy,
  output logic              done,
  output logic              key_valid,
  output logic              key_invalid,
  output logic [ADDR_W-1:0] fail_index
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_WAIT,
    S_CHECK,
    S_PASS,
    S_FAIL
  } state_t;

  // WAIT lasts READ_LAT-1 clocks. The counter starts at 0, so WAIT leaves
  // when the counter reaches READ_LAT-2. When READ_LAT=1, WAIT is never
  // entered and this value is not used.
  localparam int WAIT_LAST_INT = (READ_LAT > 1) ? READ_LAT - 2 : 0;
  localparam logic [2:0] WAIT_LAST = 3'(WAIT_LAST_INT);
  localparam logic [ADDR_W-1:0] LAST_K = ADDR_W'(MSG_LEN - 1);

  state_t            state;
  logic [ADDR_W-1:0] k;
  logic [2:0]        wait_cnt;
  logic              start_q;
  logic              accept;

  // Classifies the byte currently on the RAM read port.
  always_comb begin
    accept = (q_d == 8'h20) || ((q_d >= 8'h61) && (q_d <= 8'h7A));
`ifdef ALLOW_UPPER_EN
    if ((q_d >= 8'h41) && (q_d <= 8'h5A)) begin
      accept = 1'b1;
    end
`else
    accept = accept;
`endif
  end

  // Sequencer with registered outputs. Each output is updated on the same
  // edge as the state change it belongs to. Because of this, address_d
  // holds byte k for the whole ADDR/WAIT span. The read-data sample in CHECK
  // therefore falls exactly READ_LAT+1 edges after the address was set.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_IDLE;
      k           <= '0;
      wait_cnt    <= '0;
      start_q     <= 1'b0;
      address_d   <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      key_valid   <= 1'b0;
      key_invalid <= 1'b0;
      fail_index  <= '0;
    end else begin
      start_q <= start;
      case (state)
        S_IDLE: begin
          if (start && !start_q) begin
            state     <= S_ADDR;
            k         <= '0;
            address_d <= '0;
            busy      <= 1'b1;
          end
        end
        S_ADDR: begin
          wait_cnt <= '0;
          if (READ_LAT == 1) begin
            state <= S_CHECK;
          end else begin
            state <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (wait_cnt == WAIT_LAST) begin
            state <= S_CHECK;
          end else begin
            wait_cnt <= wait_cnt + 3'd1;
          end
        end
        S_CHECK: begin
          if (!accept) begin
            state       <= S_FAIL;
            fail_index  <= k;
            address_d   <= '0;
            busy        <= 1'b0;
            done        <= 1'b1;
            key_invalid <= 1'b1;
          end else if (k == LAST_K) begin
            state     <= S_PASS;
            address_d <= '0;
            busy      <= 1'b0;
            done      <= 1'b1;
            key_valid <= 1'b1;
          end else begin
            // k stops at MSG_LEN-1, so this increment can never wrap.
            state     <= S_ADDR;
            k         <= k + 1'b1;
            address_d <= k + 1'b1;
          end
        end
        S_PASS, S_FAIL: begin
          // The result is held until the decrypt stage drops start.
          // IDLE then needs a fresh rising edge, so a start that stays
          // high cannot retrigger a check.
          if (!start) begin
            state       <= S_IDLE;
            k           <= '0;
            done        <= 1'b0;
            key_valid   <= 1'b0;
            key_invalid <= 1'b0;
            fail_index  <= '0;
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rc4_message_checker.sv
// tb_rc4_message_checker
//
// Purpose: directed self-checking bench for rc4_message_checker. The bench
// models the decrypted RAM as a byte array followed by a READ_LAT-deep
// output pipeline. Expected latencies and results are hand-computed.
// Per-byte cost is READ_LAT+1 = 3 clocks at the default parameters.

module tb_rc4_message_checker;

  localparam int MSG_LEN  = 32;
  localparam int ADDR_W   = 8;
  localparam int READ_LAT = 2;

  logic              clk = 1'b0;
  logic              reset;
  logic              start;
  logic [ADDR_W-1:0] address_d;
  logic [7:0]        q_d;
  logic              busy;
  logic              done;
  logic              key_valid;
  logic              key_invalid;
  logic [ADDR_W-1:0] fail_index;

  logic [7:0] mem  [0:255];
  logic [7:0] pipe [0:READ_LAT-1];

  int checks  = 0;
  int errors  = 0;
  int overlap = 0;

  rc4_message_checker #(
    .MSG_LEN (MSG_LEN),
    .ADDR_W  (ADDR_W),
    .READ_LAT(READ_LAT)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .address_d  (address_d),
    .q_d        (q_d),
    .busy       (busy),
    .done       (done),
    .key_valid  (key_valid),
    .key_invalid(key_invalid),
    .fail_index (fail_index)
  );

  always #5 clk = ~clk;

  // RAM model: data appears READ_LAT clocks after the address.
  always @(posedge clk) begin
    pipe[0] <= mem[address_d];
    for (int i = 1; i < READ_LAT; i++) pipe[i] <= pipe[i-1];
  end
  assign q_d = pipe[READ_LAT-1];

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic level);
    @(negedge clk);
    start = level;
  endtask

  task automatic fillMem(input logic [7:0] value);
    for (int i = 0; i < 256; i++) mem[i] = value;
  endtask

  // Counts edges from the most recent edge until done is seen, within a
  // bounded budget. Also tracks the highest address and any busy/done overlap.
  task automatic waitDone(output int edges, output int max_addr);
    edges    = 0;
    max_addr = 0;
    do begin
      @(posedge clk);
      #1;
      edges++;
      if (int'(address_d) > max_addr) max_addr = int'(address_d);
      if (busy && done) overlap++;
    end while (!done && edges < 400);
    if (!done) checkOutput("timeout_done", 32'(done), 32'd1);
  endtask

  task automatic runCheck(input string name, input int exp_edges,
                          input bit exp_pass, input int exp_idx);
    int edges;
    int max_addr;
    applyStimulus(1'b1);
    @(posedge clk);
    waitDone(edges, max_addr);
    checkOutput({name, "_edges"}, 32'(edges), 32'(exp_edges));
    checkOutput({name, "_key_valid"}, 32'(key_valid), 32'(exp_pass));
    checkOutput({name, "_key_invalid"}, 32'(key_invalid), 32'(!exp_pass));
    checkOutput({name, "_fail_index"}, 32'(fail_index), 32'(exp_idx));
    checkOutput({name, "_busy"}, 32'(busy), 32'd0);
    checkOutput({name, "_max_addr"}, 32'(max_addr),
                32'(exp_pass ? MSG_LEN - 1 : exp_idx));
  endtask

  task automatic releaseStart(input string name);
    applyStimulus(1'b0);
    @(posedge clk);
    #1;
    checkOutput({name, "_rel_done"}, 32'(done), 32'd0);
    checkOutput({name, "_rel_flags"}, {30'd0, key_valid, key_invalid}, 32'd0);
    checkOutput({name, "_rel_fail_index"}, 32'(fail_index), 32'd0);
  endtask

  initial begin
    int hits;
    int busy_seen;
    reset = 1'b1;
    start = 1'b0;
    fillMem(8'h61);
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_outputs",
                {address_d, fail_index, 4'd0, busy, done, key_valid, key_invalid},
                32'd0);
    @(negedge clk);
    reset = 1'b0;

    // All lowercase 'a': PASS after 32 * 3 edges.
    runCheck("all_a", 96, 1'b1, 0);
    releaseStart("all_a");

    // Byte 5 is '{', just above 'z'.
    mem[5] = 8'h7B;
    runCheck("byte5_7b", 18, 1'b0, 5);
    releaseStart("byte5_7b");

    // Boundary pattern: alternating space and 'z' must pass.
    for (int i = 0; i < MSG_LEN; i++) mem[i] = (i % 2 == 0) ? 8'h20 : 8'h7A;
    runCheck("space_z_mix", 96, 1'b1, 0);
    releaseStart("space_z_mix");

    // Byte 0 just below 'a', and byte 0 just below space.
    fillMem(8'h61);
    mem[0] = 8'h60;
    runCheck("byte0_60", 3, 1'b0, 0);
    releaseStart("byte0_60");
    mem[0] = 8'h1F;
    runCheck("byte0_1f", 3, 1'b0, 0);
    releaseStart("byte0_1f");
    mem[0] = 8'hFF;
    runCheck("byte0_ff", 3, 1'b0, 0);
    releaseStart("byte0_ff");

    // Uppercase 'A' in the last byte. Both outcomes take 96 edges.
    fillMem(8'h61);
    mem[31] = 8'h41;
`ifdef ALLOW_UPPER_EN
    runCheck("byte31_upper", 96, 1'b1, 0);
`else
    runCheck("byte31_upper", 96, 1'b0, 31);
`endif
    releaseStart("byte31_upper");

    // Reset while k=10 with start held high.
    fillMem(8'h61);
    applyStimulus(1'b1);
    hits = 0;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk);
      #1;
      if (address_d == 8'd10) begin
        hits = 1;
        break;
      end
    end
    checkOutput("reach_k10", 32'(hits), 32'd1);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("midreset_outputs",
                {address_d, fail_index, 4'd0, busy, done, key_valid, key_invalid},
                32'd0);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("rerun_launch", {23'd0, busy, address_d}, {23'd0, 1'b1, 8'd0});
    begin
      int edges;
      int max_addr;
      waitDone(edges, max_addr);
      checkOutput("rerun_edges", 32'(edges), 32'd96);
      checkOutput("rerun_key_valid", 32'(key_valid), 32'd1);
    end

    // Hold start for 50 clocks after PASS: there must be no new activity.
    busy_seen = 0;
    for (int i = 0; i < 50; i++) begin
      @(posedge clk);
      #1;
      if (busy || address_d != 8'd0) busy_seen++;
    end
    checkOutput("hold_no_reads", 32'(busy_seen), 32'd0);
    checkOutput("hold_done", {30'd0, done, key_valid}, 32'd3);
    releaseStart("hold");
    runCheck("re_raise", 96, 1'b1, 0);
    releaseStart("re_raise");

    checkOutput("busy_done_overlap", 32'(overlap), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
